shift_seq_unit: RTL and testbench

Multi-pass sequencer that sits directly upstream of the 32-bit combinational barrel shifter. It accepts shift/rotate commands over a valid/ready handshake and extends the amount range to 0..63 by driving the shifter for up to three passes, with a registered working value. It captures the shifter's output and presents the final result downstream over a second valid/ready handshake.

---
 rtl/shift_seq_unit.sv | 111 +++++++++++
 tb/tb_shift_seq_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - multi-pass sequencer driving a 32-bit barrel shifter for amounts 0..63
// Optional result counter enabled by SHIFT_SEQ_STATS_EN.
module shift_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [5:0]       cmd_amt,
    input  logic             cmd_dir,
    input  logic             cmd_rot,
    output logic [WIDTH-1:0] sh_in,
    output logic [4:0]       sh_amt,
    output logic             sh_dir,
    output logic             sh_rot,
    input  logic [WIDTH-1:0] sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero
`ifdef SHIFT_SEQ_STATS_EN
    ,
    output logic [15:0]      res_count
`endif
);

    typedef enum logic [2:0] {IDLE, LO, HI_A, HI_B, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] wreg;
    logic             amt_hi;
    logic [4:0]       amt_lo;
    logic             dir;
    logic             rot;
    logic             accept;

    assign accept   = cmd_valid & cmd_ready;
    assign sh_in    = wreg;
    assign res_data = wreg;
    assign sh_dir   = dir;
    assign sh_rot   = rot;
    assign res_zero = res_valid & (wreg == '0);

    // A 32..63 amount is the low part plus two 16-bit passes, since the shifter only takes 0..31.
    always_comb begin
        next_state = state;
        sh_amt     = 5'd0;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = LO;
            end
            LO: begin
                sh_amt     = amt_lo;
                next_state = amt_hi ? HI_A : DONE;
            end
            HI_A: begin
                sh_amt     = 5'd16;
                next_state = HI_B;
            end
            HI_B: begin
                sh_amt     = 5'd16;
                next_state = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                cmd_ready = res_ready;
                if (res_ready) next_state = cmd_valid ? LO : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wreg   <= '0;
            amt_hi <= 1'b0;
            amt_lo <= 5'd0;
            dir    <= 1'b0;
            rot    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                wreg   <= cmd_data;
                amt_hi <= cmd_amt[5];
                amt_lo <= cmd_amt[4:0];
                dir    <= cmd_dir;
                rot    <= cmd_rot;
            end else if (state == LO || state == HI_A || state == HI_B) begin
                wreg <= sh_out;
            end
        end
    end

`ifdef SHIFT_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count <= 16'd0;
        end else if (res_valid && res_ready) begin
            res_count <= res_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - table-driven bench for shift_seq_unit with a behavioural barrel shifter
module tb_shift_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = '0;
    logic [5:0]  cmd_amt = '0;
    logic        cmd_dir = 1'b0;
    logic        cmd_rot = 1'b0;
    logic [31:0] sh_in;
    logic [4:0]  sh_amt;
    logic        sh_dir;
    logic        sh_rot;
    logic [31:0] sh_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_zero;
`ifdef SHIFT_SEQ_STATS_EN
    logic [15:0] res_count;
    logic [15:0] cnt0;
`endif

    int passed = 0;
    int total = 0;

    shift_seq_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .cmd_amt(cmd_amt),
        .cmd_dir(cmd_dir),
        .cmd_rot(cmd_rot),
        .sh_in(sh_in),
        .sh_amt(sh_amt),
        .sh_dir(sh_dir),
        .sh_rot(sh_rot),
        .sh_out(sh_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_zero(res_zero)
`ifdef SHIFT_SEQ_STATS_EN
        ,
        .res_count(res_count)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] dbl;
    logic [63:0] rr;
    logic [63:0] rl;
    always_comb begin
        dbl = {sh_in, sh_in};
        rr  = dbl >> sh_amt;
        rl  = dbl << sh_amt;
        if (sh_rot) sh_out = sh_dir ? rr[31:0] : rl[63:32];
        else        sh_out = sh_dir ? (sh_in >> sh_amt) : (sh_in << sh_amt);
    end

    typedef struct {
        logic [31:0] data;
        logic [5:0]  amt;
        logic        dir;
        logic        rot;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int         cyc;
        int         npass;
        logic [4:0] amts[4];
        res_ready = 1'b1;
        cmd_data  = v.data;
        cmd_amt   = v.amt;
        cmd_dir   = v.dir;
        cmd_rot   = v.rot;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc   = 1;
        npass = 0;
        while (!res_valid && cyc < 8) begin
            if (npass < 4) amts[npass] = sh_amt;
            npass++;
            check($sformatf("v%0d_stall", idx), {31'd0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("v%0d_latency", idx), cyc, v.amt[5] ? 32'd4 : 32'd2);
        check($sformatf("v%0d_lo_amt", idx), {27'd0, amts[0]}, {27'd0, v.amt[4:0]});
        if (v.amt[5]) begin
            check($sformatf("v%0d_hia_amt", idx), {27'd0, amts[1]}, 32'd16);
            check($sformatf("v%0d_hib_amt", idx), {27'd0, amts[2]}, 32'd16);
        end
        check($sformatf("v%0d_data", idx), res_data, v.exp);
        check($sformatf("v%0d_zero", idx), {31'd0, res_zero}, {31'd0, v.exp == 32'd0});
        @(posedge clk); #1;
        check($sformatf("v%0d_idle", idx), {30'd0, cmd_ready, res_valid}, 32'd2);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{32'h0000_0001, 6'd4,  1'b0, 1'b0, 32'h0000_0010};
        vecs[1] = '{32'h8000_0000, 6'd40, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h0000_00F1, 6'd36, 1'b1, 1'b1, 32'h1000_000F};
        vecs[3] = '{32'hDEAD_BEEF, 6'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{32'h8000_0001, 6'd1,  1'b0, 1'b1, 32'h0000_0003};
        vecs[5] = '{32'hFFFF_FFFF, 6'd31, 1'b0, 1'b0, 32'h8000_0000};
        vecs[6] = '{32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h1234_5678, 6'd63, 1'b1, 1'b1, 32'h2468_ACF0};
        vecs[8] = '{32'h1234_5678, 6'd40, 1'b0, 1'b1, 32'h3456_7812};
        vecs[9] = '{32'hF000_0000, 6'd28, 1'b1, 1'b0, 32'h0000_000F};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_outs", {res_valid, res_zero, sh_dir, sh_rot, sh_amt}, 9'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_shin", sh_in, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst", {30'd0, cmd_ready, res_valid}, 32'd2);

        for (int i = 0; i < 10; i++) run_cmd(vecs[i], i);

        // Backpressure then back-to-back accept from DONE
        res_ready = 1'b0;
        cmd_data = 32'h3; cmd_amt = 6'd2; cmd_dir = 1'b0; cmd_rot = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_valid", {31'd0, res_valid}, 32'd1);
        check("bp_data", res_data, 32'hC);
`ifdef SHIFT_SEQ_STATS_EN
        cnt0 = res_count;
`endif
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold", res_data, 32'hC);
            check("bp_ready", {30'd0, cmd_ready, res_valid}, 32'd1);
        end
        res_ready = 1'b1;
        cmd_data = 32'h1; cmd_amt = 6'd1; cmd_dir = 1'b1; cmd_rot = 1'b1; cmd_valid = 1'b1;
        #1;
        check("b2b_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        check("b2b_lo", {30'd0, cmd_ready, res_valid}, 32'd0);
        check("b2b_amt", {27'd0, sh_amt}, 32'd1);
`ifdef SHIFT_SEQ_STATS_EN
        check("b2b_count", {16'd0, res_count}, {16'd0, cnt0 + 16'd1});
`endif
        @(posedge clk); #1;
        check("b2b_valid", {31'd0, res_valid}, 32'd1);
        check("b2b_data", res_data, 32'h8000_0000);

        // Asynchronous reset while holding a result
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_outs", {res_valid, res_zero, sh_dir, sh_rot, sh_amt}, 9'd0);
        check("arst_data", res_data, 32'd0);
        check("arst_shin", sh_in, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef SHIFT_SEQ_STATS_EN
        check("arst_count", {16'd0, res_count}, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", {30'd0, cmd_ready, res_valid}, 32'd2);

        // Reset during HI_A of an amount-50 command
        cmd_data = 32'h1; cmd_amt = 6'd50; cmd_dir = 1'b0; cmd_rot = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_hia_amt", {27'd0, sh_amt}, 32'd16);
        check("mid_hia_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {30'd0, cmd_ready, res_valid}, 32'd2);
        check("mid_rst_amt", {27'd0, sh_amt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        check("mid_no_result", {31'd0, seen}, 32'd0);
        run_cmd('{32'h0004_0000, 6'd50, 1'b1, 1'b1, 32'h0000_0001}, 10);
`ifdef SHIFT_SEQ_STATS_EN
        check("final_count", {16'd0, res_count}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
